// File: rtl/arith_unit.sv
// Registered arithmetic unit: eight add/subtract/increment/negate opcodes on
// zero-extended unsigned operands, with a signed WIDTH+1-bit result and flags.
module arith_unit #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [2:0]       sel,
  output logic [WIDTH:0]   out,
  output logic             valid,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic             err
);

  localparam int EW = WIDTH + 2;

  logic signed [EW-1:0] a_x, b_x, one_x, res_x;
  logic                 illegal;

  logic [WIDTH:0] out_d, out_q;
  logic           ovf_d, ovf_q;
  logic           zero_d, zero_q;
  logic           neg_d, neg_q;
  logic           err_d, err_q;
  logic           valid_q;

  // Two extra bits hold every exact result, so overflow is just a
  // disagreement between the top bit and the kept sign bit.
  always_comb begin
    a_x     = $signed({2'b00, a_in});
    b_x     = $signed({2'b00, b_in});
    one_x   = EW'(1);
    illegal = 1'b0;
    res_x   = '0;
    case (sel)
      3'b000:  res_x = a_x + b_x;
      3'b001:  res_x = a_x - b_x;
      3'b010:  res_x = b_x - a_x;
      3'b011:  res_x = a_x + one_x;
      3'b100:  res_x = a_x - one_x;
      3'b101:  res_x = b_x + one_x;
      3'b110:  res_x = b_x - one_x;
      3'b111:  res_x = -a_x;
      default: illegal = 1'b1;
    endcase
    out_d  = res_x[WIDTH:0];
    ovf_d  = !illegal && (res_x[EW-1] ^ res_x[EW-2]);
    zero_d = (out_d == '0);
    neg_d  = out_d[WIDTH];
    err_d  = illegal;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= en;
      if (en) begin
        out_q  <= out_d;
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
        neg_q  <= neg_d;
        err_q  <= err_d;
      end
    end
  end

  assign out   = out_q;
  assign valid = valid_q;
  assign ovf   = ovf_q;
  assign zero  = zero_q;
  assign neg   = neg_q;
  assign err   = err_q;

endmodule

// File: tb/tb_arith_unit.sv
// Bench for arith_unit: directed steps from the plan plus a random stream,
// all checked against an integer-arithmetic reference model.
module tb_arith_unit;
  localparam int W = 2;

  logic         clk, rst, en;
  logic [W-1:0] a_in, b_in;
  logic [2:0]   sel;
  logic [W:0]   out;
  logic         valid, ovf, zero, neg, err;

  int total = 0;
  int bad   = 0;

  logic [W:0] m_out;
  logic       m_valid, m_ovf, m_zero, m_neg, m_err;

  arith_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .a_in(a_in), .b_in(b_in), .sel(sel),
    .out(out), .valid(valid), .ovf(ovf), .zero(zero), .neg(neg), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exact(input int a, input int b, input logic [2:0] s);
    case (s)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return b - a;
      3'd3:    return a + 1;
      3'd4:    return a - 1;
      3'd5:    return b + 1;
      3'd6:    return b - 1;
      default: return -a;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, let the model advance at the edge, compare at negedge.
  task automatic cyc(input logic r, input logic e, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [2:0] s, input string tag);
    int ex;
    int lo, hi;
    rst = r; en = e; a_in = a; b_in = b; sel = s;
    @(posedge clk);
    lo = -(1 << W);
    hi = (1 << W) - 1;
    if (r) begin
      m_out = '0; m_valid = 1'b0; m_ovf = 1'b0; m_zero = 1'b1; m_neg = 1'b0; m_err = 1'b0;
    end else if (!e) begin
      m_valid = 1'b0;
    end else if ($isunknown(s)) begin
      m_out = '0; m_valid = 1'b1; m_ovf = 1'b0; m_zero = 1'b1; m_neg = 1'b0; m_err = 1'b1;
    end else begin
      ex      = exact(int'(a), int'(b), s);
      m_out   = ex[W:0];
      m_valid = 1'b1;
      m_ovf   = (ex < lo) || (ex > hi);
      m_zero  = (ex[W:0] == 0);
      m_neg   = ex[W];
      m_err   = 1'b0;
    end
    @(negedge clk);
    chk({tag, ".out"},   32'(out),   32'(m_out));
    chk({tag, ".valid"}, 32'(valid), 32'(m_valid));
    chk({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
    chk({tag, ".zero"},  32'(zero),  32'(m_zero));
    chk({tag, ".neg"},   32'(neg),   32'(m_neg));
    chk({tag, ".err"},   32'(err),   32'(m_err));
  endtask

  initial begin
    logic [W:0] tab [8];
    logic [2:0] zs;
    tab = '{3'b100, 3'b000, 3'b000, 3'b011, 3'b001, 3'b011, 3'b001, 3'b110};
    zs  = 3'bzzz;
    rst = 1'b1; en = 1'b1; a_in = '0; b_in = '0; sel = '0;

    // Reset held two cycles with en high
    cyc(1, 1, 2'd1, 2'd1, 3'd0, "rst0");
    cyc(1, 1, 2'd1, 2'd1, 3'd0, "rst1");
    chk("rst.out_const", 32'(out), 32'd0);
    chk("rst.zero_const", 32'(zero), 32'd1);
    cyc(0, 1, 2'd1, 2'd1, 3'd0, "first");
    chk("first.out_const", 32'(out), 32'd2);

    // Opcode sweep with a=b=2, also against the hand-derived table
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 2'd2, 2'd2, 3'(i), $sformatf("sweep%0d", i));
      chk($sformatf("sweep_tab%0d", i), 32'(out), 32'(tab[i]));
    end

    // Negative range
    cyc(0, 1, 2'd0, 2'd3, 3'd1, "neg_a_minus_b");
    chk("neg_a_minus_b.const", 32'(out), 32'b101);
    cyc(0, 1, 2'd0, 2'd3, 3'd4, "neg_a_dec");
    chk("neg_a_dec.const", 32'(out), 32'b111);
    cyc(0, 1, 2'd0, 2'd3, 3'd2, "neg_b_minus_a");

    // Overflow boundaries
    cyc(0, 1, 2'd3, 2'd3, 3'd0, "ovf_6");
    chk("ovf_6.const", 32'(ovf), 32'd1);
    cyc(0, 1, 2'd3, 2'd3, 3'd3, "ovf_4");
    chk("ovf_4.const", 32'({ovf, neg, zero}), 32'b110);
    cyc(0, 1, 2'd1, 2'd2, 3'd0, "edge_3");
    chk("edge_3.const", 32'({out, ovf}), 32'b0110);

    // Illegal opcode, then hold for three idle cycles
    cyc(0, 1, 2'd3, 2'd1, zs, "illegal");
    cyc(0, 0, 2'd1, 2'd2, 3'd1, "hold0");
    cyc(0, 0, 2'd2, 2'd0, 3'd7, "hold1");
    cyc(0, 0, 2'd3, 2'd3, 3'd0, "hold2");

    // Reset pulse in the middle of a stream
    cyc(0, 1, 2'd1, 2'd2, 3'd1, "ms0");
    cyc(0, 1, 2'd1, 2'd2, 3'd2, "ms1");
    cyc(1, 1, 2'd1, 2'd2, 3'd1, "ms_rst");
    cyc(0, 1, 2'd1, 2'd2, 3'd2, "ms2");
    cyc(0, 1, 2'd3, 2'd0, 3'd7, "ms3");

    // Random stream with occasional idles and resets
    for (int i = 0; i < 300; i++) begin
      cyc(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
          W'($urandom), W'($urandom), 3'($urandom), $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/arith_unit.md
Name: arith_unit

Overview:
Registered 2-bit arithmetic unit with an 8-operation opcode select. Two unsigned operands produce a signed two's-complement result of WIDTH+1 bits, plus status flags. It is the arithmetic half of the small ALU; a sibling logic unit and an output mux sit alongside it. One result is issued per enabled cycle, with a fixed 1-cycle latency.

Parameters:
WIDTH, 2, operand width in bits; the result is WIDTH+1 bits signed.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
en  input  1  operation strobe; inputs are sampled when high
a_in  input  WIDTH  operand A, unsigned
b_in  input  WIDTH  operand B, unsigned
sel  input  3  opcode
out  output  WIDTH+1  signed result, registered
valid  output  1  high for one cycle when out holds a new result
ovf  output  1  true result is not representable in signed WIDTH+1 bits
zero  output  1  out == 0
neg  output  1  out MSB (result negative)
err  output  1  sel contained non-0/1 bits in simulation; opcode illegal

Behaviour:
- Clocking: all outputs are registered on the clk rising edge. There are no combinational paths from inputs to outputs.
- Reset: when rst=1 at a clk edge, out=0, valid=0, ovf=0, zero=1, neg=0, err=0. rst has priority over en. A reset mid-stream discards the in-flight result.
- Operand extension: a_in and b_in are zero-extended to WIDTH+2 bits. The operation is computed exactly at that width.
- Result: out = low WIDTH+1 bits of the exact result (wrap-around).
- ovf = 1 when the exact result is outside [-2^WIDTH, 2^WIDTH - 1]. For WIDTH=2 that range is [-4, 3].
- Opcodes:
  - 000 a+b
  - 001 a-b
  - 010 b-a
  - 011 a+1
  - 100 a-1
  - 101 b+1
  - 110 b-1
  - 111 -a (two's-complement negate)
- Illegal sel (any X/Z bit, detected with a case default): out=0, ovf=0, zero=1, neg=0, err=1, valid=1. Synthesis treats this as unreachable.
- Latency: when en=1 at edge N, the result and flags appear after edge N and valid=1 for that cycle.
- When en=0 at an edge: valid drops to 0, and out plus all flags hold their previous values.
- Back-to-back en=1 yields one result per cycle with no bubbles.
- zero and neg are derived from the truncated out value, not the exact result. Example: 4 wraps to 100, so zero=0 and neg=1, with ovf=1.
- No state beyond the output registers. There is no FSM.

Test Plan:
- Reset: assert rst 2 cycles with en=1, sel=000 -> out=000, valid=0, zero=1, ovf=0. Deassert rst -> the first result appears 1 cycle later.
- Opcode sweep, a=2, b=2, en=1, sel stepping 000..111 one per cycle (each result one cycle after its sel):

  | sel | out | flags |
  |-----|-----|-------|
  | 000 | 100 | ovf=1, neg=1 |
  | 001 | 000 | zero=1 |
  | 010 | 000 | zero=1 |
  | 011 | 011 | — |
  | 100 | 001 | — |
  | 101 | 011 | — |
  | 110 | 001 | — |
  | 111 | 110 | neg=1, ovf=0 |

- Negative range, a=0, b=3:
  - sel=001 -> 101 (-3), neg=1, ovf=0
  - sel=100 -> 111 (-1), neg=1
  - sel=010 -> 011
- Overflow boundaries, a=3, b=3:
  - sel=000 -> exact 6, out=110, ovf=1
  - a=3, sel=011 -> exact 4, out=100, ovf=1
  - a=1, b=2, sel=000 -> 011, ovf=0
- Illegal/hold: sel=zzz with en=1 -> out=000, err=1, valid=1. Then en=0 for 3 cycles -> valid=0, and out/flags hold.
- Reset mid-stream: en=1 with alternating opcodes, pulse rst for 1 cycle -> the next edge shows reset values. The stream resumes with correct results 1 cycle after rst drops.
